// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: walks LED addresses 0..count-1, fetches each pixel from colour RAM,
// hands it to the serializer over valid/ready, then holds a latch gap and flags completion.

module led_frame_sequencer #(
    parameter int unsigned LED_AW        = 8,
    parameter int unsigned PIX_W         = 24,
    parameter int unsigned LATCH_DEFAULT = 2500
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic [1:0]        i_address,
    input  logic              i_chipselect,
    input  logic              i_write_n,
    input  logic [31:0]       i_writedata,
    output logic [31:0]       o_readdata,

    output logic [LED_AW-1:0] o_led_addr,
    output logic              o_ram_rd,
    input  logic [PIX_W-1:0]  i_ram_rdata,

    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,

    output logic              o_frame_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StSend,
        StLatch
    } state_t;

    localparam logic [LED_AW-1:0] IdxOne = LED_AW'(1);

    state_t              r_state;
    state_t              w_state_next;

    logic [LED_AW-1:0]   r_idx;
    logic [LED_AW-1:0]   w_idx_next;
    logic [LED_AW-1:0]   r_count;
    logic [LED_AW-1:0]   r_count_sh;
    logic [15:0]         r_latch;
    logic [15:0]         r_latch_sh;
    logic [15:0]         r_gap;
    logic                r_cont;
    logic                r_done;
    logic                r_abort_pend;
    logic [PIX_W-1:0]    r_pix_data;

    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_wr_count;
    logic                w_wr_status;
    logic                w_wr_latch;
    logic                w_start;
    logic                w_abort;
    logic                w_last;
    logic                w_gap_zero;
    logic                w_load_shadow;
    logic                w_load_gap;
    logic                w_capture;
    logic                w_frame_end;
    logic                w_unused;

    // Avalon write decode
    assign w_wr        = i_chipselect & ~i_write_n;
    assign w_wr_ctrl   = w_wr & (i_address == 2'd0);
    assign w_wr_count  = w_wr & (i_address == 2'd1);
    assign w_wr_status = w_wr & (i_address == 2'd2);
    assign w_wr_latch  = w_wr & (i_address == 2'd3);
    assign w_start     = w_wr_ctrl & i_writedata[0];
    assign w_abort     = w_wr_ctrl & i_writedata[2];
    assign w_unused    = ^i_writedata[31:16];

    assign w_last     = (r_idx == (r_count_sh - IdxOne));
    assign w_gap_zero = (r_gap == 16'd0);

    // Next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_load_shadow = 1'b0;
        w_load_gap    = 1'b0;
        w_capture     = 1'b0;
        w_frame_end   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start && !w_abort && (r_count != '0)) begin
                    w_state_next  = StFetch;
                    w_idx_next    = '0;
                    w_load_shadow = 1'b1;
                end
            end

            StFetch: begin
                w_state_next = w_abort ? StIdle : StWait;
            end

            StWait: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                end else begin
                    w_state_next = StSend;
                    w_capture    = 1'b1;
                end
            end

            StSend: begin
                // An abort here only takes effect once the pending pixel is accepted
                if (i_pix_ready) begin
                    if (w_abort || r_abort_pend) begin
                        w_state_next = StIdle;
                    end else if (w_last) begin
                        w_state_next = StLatch;
                        w_load_gap   = 1'b1;
                    end else begin
                        w_state_next = StFetch;
                        w_idx_next   = r_idx + IdxOne;
                    end
                end
            end

            StLatch: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                end else if (w_gap_zero) begin
                    w_frame_end = 1'b1;
                    if (r_cont && (r_count != '0)) begin
                        w_state_next  = StFetch;
                        w_idx_next    = '0;
                        w_load_shadow = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Sequencer state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_count_sh   <= '0;
            r_latch_sh   <= '0;
            r_gap        <= '0;
            r_abort_pend <= 1'b0;
            r_pix_data   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_abort_pend <= (w_state_next == StSend) && (r_abort_pend || w_abort);

            if (w_load_shadow) begin
                r_count_sh <= r_count;
                r_latch_sh <= r_latch;
            end

            if (w_load_gap) begin
                r_gap <= r_latch_sh;
            end else if ((r_state == StLatch) && !w_gap_zero) begin
                r_gap <= r_gap - 16'd1;
            end

            if (w_capture) begin
                r_pix_data <= i_ram_rdata;
            end
        end
    end

    // Software-visible registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_latch <= 16'(LATCH_DEFAULT);
            r_cont  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_cont <= i_writedata[1];
            end
            if (w_wr_count) begin
                r_count <= i_writedata[LED_AW-1:0];
            end
            if (w_wr_latch) begin
                r_latch <= i_writedata[15:0];
            end
            // Completion beats a same-cycle clear
            if (w_frame_end) begin
                r_done <= 1'b1;
            end else if (w_wr_status && i_writedata[1]) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        o_readdata = '0;
        unique case (i_address)
            2'd0:    o_readdata[1]          = r_cont;
            2'd1:    o_readdata[LED_AW-1:0] = r_count;
            2'd2:    o_readdata[1:0]        = {r_done, (r_state != StIdle)};
            2'd3:    o_readdata[15:0]       = r_latch;
            default: o_readdata             = '0;
        endcase
    end

    assign o_led_addr   = r_idx;
    assign o_ram_rd     = (r_state == StFetch);
    assign o_pix_valid  = (r_state == StSend);
    assign o_pix_data   = r_pix_data;
    assign o_frame_done = w_frame_end;

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Avalon-MM-controlled sequencer that walks the LED address space 0..led_count-1 once per frame.
- For each LED it reads a pixel from the colour RAM and hands it to the downstream LED serializer over a valid/ready handshake.
- After the last LED it holds a programmable latch gap, then flags frame completion.
- Replaces direct software driving of the LED address port: the Nios II programs count/gap and issues start; hardware sequences the frame.

Parameters:
- LED_AW, 8, LED address width; maximum led_count = 2^LED_AW - 1.
- PIX_W, 24, pixel width (GRB 8:8:8).
- LATCH_DEFAULT, 2500, reset value of the latch-gap register in clk cycles (50 us at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states.
- led_addr  out  LED_AW  colour-RAM / LED address of the current LED.
- ram_rd  out  1  colour-RAM read strobe; RAM has 1-cycle read latency.
- ram_rdata  in  PIX_W  colour-RAM read data.
- pix_data  out  PIX_W  pixel to serializer.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  serializer accepts pixel.
- frame_done  out  1  1-cycle pulse at end of latch gap (IRQ source).

Behaviour:
- Registers; write = chipselect & ~write_n; unused bits read 0.
  - addr0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 CONT (R/W); bit2 ABORT (write-1 pulse, reads 0).
  - addr1 COUNT: [LED_AW-1:0] R/W.
  - addr2 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
  - addr3 LATCH: [15:0] R/W.
- Reset values: COUNT=0, LATCH=LATCH_DEFAULT, CONT=0, DONE=0, state IDLE, led_addr=0, ram_rd=0, pix_data=0, pix_valid=0, frame_done=0.
- COUNT and LATCH are shadowed on frame start; writes while BUSY take effect at the next frame.
- FSM states:
  - IDLE: on START with COUNT!=0, latch shadows, idx=0, go to FETCH next cycle. START with COUNT=0 is ignored; DONE stays unchanged.
  - FETCH (1 cycle): led_addr=idx, ram_rd=1, then go to WAIT.
  - WAIT (1 cycle): ram_rd=0; at exit capture ram_rdata into pix_data, then go to SEND.
  - SEND: pix_valid=1, pix_data stable until the cycle with pix_valid&pix_ready.
    - On handshake with idx==count-1: go to LATCH, gap counter=latch shadow.
    - On handshake otherwise: idx+1, go to FETCH.
  - LATCH: counter decrements each cycle; on the cycle it reads 0, set DONE and pulse frame_done.
    - If CONT=1: re-latch shadows, idx=0, go to FETCH. If the new COUNT=0, go to IDLE instead.
    - Else go to IDLE.
    - LATCH=0 gives a 1-cycle gap.
- Minimum time per LED = 3 cycles (FETCH, WAIT, SEND with pix_ready already high).
- BUSY = state != IDLE.
- ABORT:
  - In FETCH, WAIT or LATCH: immediate return to IDLE; no DONE, no frame_done.
  - In SEND: deferred until the handshake completes, so pix_valid never drops unaccepted, then go to IDLE.
  - In IDLE: no effect.
- Simultaneous events:
  - START while BUSY: ignored.
  - START and ABORT in the same write: ABORT wins.
  - DONE clear-write in the same cycle DONE sets: set wins.
- led_addr holds its last value outside FETCH. idx never wraps, since count-1 is at most 2^LED_AW-2.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; a pending pixel is discarded.

Test Plan:
- Reset, read all registers -> COUNT=0, LATCH=2500, STATUS=0, CTRL=0; pix_valid=0.
- COUNT=3, LATCH=4, START, pix_ready tied 1, RAM[i]=0x0A0B00+i:
  - led_addr 0,1,2 with ram_rd; pix_data 0x0A0B00, 0x0A0B01, 0x0A0B02.
  - frame_done pulses 5 cycles after the third handshake; DONE=1; BUSY=0.
- Same frame with pix_ready low for 7 cycles at LED 1 -> pix_valid and pix_data=0x0A0B01 held stable for those 7 cycles; no led_addr advance.
- CONT=1, COUNT=2; write COUNT=1 mid-frame -> first frame sends 2 pixels, second frame sends 1; frame_done pulses each frame.
- ABORT during LATCH -> IDLE next cycle, no frame_done. ABORT during stalled SEND -> stays in SEND until pix_ready, then IDLE.
- START with COUNT=0 -> BUSY stays 0. Reset asserted mid-SEND -> pix_valid=0 immediately. DONE write-1 -> DONE=0.
